// File: rtl/muldiv8.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muldiv8 -- sequential unsigned multiply/divide unit
//
// Sits after the register file read ports. It accepts two operands and a
// destination index, produces one result bit per cycle, and drives the
// register file write port for one (run-qualified) cycle when the result is
// ready. Upstream stalls while busy is high.
//
// Operations (op):
//   00 MUL   : low half of a*b
//   01 MULHU : high half of a*b
//   10 DIVU  : a / b  (b == 0 -> all ones)
//   11 REMU  : a % b  (b == 0 -> a)
//
// Build option:
//   MULDIV8_DIV_EN  defined   -> restoring divider and divide-by-zero path built
//                   undefined -> no divider; ops 10/11 finish in one cycle
//                                with rd_din = 0 and a normal write pulse
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   run     in   global enable; all state frozen while low
//   start   in   request, sampled only in IDLE with run = 1
//   op      in   operation select (see above)
//   a, b    in   operands (rs1, rs2), needed only in the accept cycle
//   rd_in   in   destination register index
//   busy    out  high in CALC and DONE
//   done    out  high in DONE
//   we      out  register file write enable, high in DONE
//   rd      out  latched destination index
//   rd_din  out  result, held until the next accept
// -----------------------------------------------------------------------------
module muldiv8 #(
   parameter int BITS  = 8,
   parameter int RBITS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [BITS-1:0]  a,
   input  logic [BITS-1:0]  b,
   input  logic [RBITS-1:0] rd_in,
   output logic             busy,
   output logic             done,
   output logic             we,
   output logic [RBITS-1:0] rd,
   output logic [BITS-1:0]  rd_din
);

   localparam int CW = $clog2(BITS + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // ---------------------------------------------------------------------------
   // Iteration step functions
   // ---------------------------------------------------------------------------

   // Shift-add: multiplier sits in the low half of the product register and is
   // consumed LSB first; the multiplicand is added into the high half with its
   // carry kept, then the whole register shifts right by one.
   function automatic logic [2*BITS-1:0] mul_step(
      input logic [2*BITS-1:0] p,
      input logic [BITS-1:0]   m
   );
      logic [BITS:0] sum;
      sum = {1'b0, p[2*BITS-1:BITS]} + (p[0] ? {1'b0, m} : {(BITS+1){1'b0}});
      return {sum, p[BITS-1:1]};
   endfunction

`ifdef MULDIV8_DIV_EN
   // Restoring division: the dividend shifts out of the quotient register MSB
   // first into a BITS+1-bit partial remainder. The stored remainder is always
   // below the divisor, so only its low BITS bits need to be kept between steps.
   // Returns {remainder_next, quotient_next}.
   function automatic logic [2*BITS-1:0] div_step(
      input logic [BITS-1:0] r,
      input logic [BITS-1:0] q,
      input logic [BITS-1:0] d
   );
      logic [BITS:0] part;
      logic [BITS:0] diff;
      part = {r, q[BITS-1]};
      diff = part - {1'b0, d};
      if (part >= {1'b0, d})
         return {diff[BITS-1:0], q[BITS-2:0], 1'b1};
      else
         return {part[BITS-1:0], q[BITS-2:0], 1'b0};
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic [1:0]          op_q;
   logic [BITS-1:0]     opnd_q;   // multiplicand, or divisor for DIVU/REMU
   logic [2*BITS-1:0]   prod_q;
`ifdef MULDIV8_DIV_EN
   logic [BITS-1:0]     rem_q;
   logic [BITS-1:0]     quo_q;
   logic [2*BITS-1:0]   div_nxt;
`endif
   logic [2*BITS-1:0]   mul_nxt;
   logic [BITS-1:0]     res_calc;
   logic                accept;

   assign accept = (state == S_IDLE) && run && start;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
   assign we   = (state == S_DONE);

   // ---------------------------------------------------------------------------
   // Next-step datapath and final result select
   // ---------------------------------------------------------------------------
   assign mul_nxt = mul_step(prod_q, opnd_q);
`ifdef MULDIV8_DIV_EN
   assign div_nxt = div_step(rem_q, quo_q, opnd_q);
`endif

   // Result as it will stand after the last CALC iteration.
   always_comb begin
      res_calc = op_q[0] ? mul_nxt[2*BITS-1:BITS] : mul_nxt[BITS-1:0];
      if (op_q[1]) begin
`ifdef MULDIV8_DIV_EN
         res_calc = op_q[0] ? div_nxt[2*BITS-1:BITS] : div_nxt[BITS-1:0];
`else
         res_calc = '0;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers (no reset: contents only matter after an accept)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept) begin
         prod_q <= {{BITS{1'b0}}, b};
`ifdef MULDIV8_DIV_EN
         opnd_q <= op[1] ? b : a;
         rem_q  <= '0;
         quo_q  <= a;
`else
         opnd_q <= a;
`endif
      end else if ((state == S_CALC) && run) begin
`ifdef MULDIV8_DIV_EN
         if (op_q[1]) begin
            rem_q <= div_nxt[2*BITS-1:BITS];
            quo_q <= div_nxt[BITS-1:0];
         end else begin
            prod_q <= mul_nxt;
         end
`else
         prod_q <= mul_nxt;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM, counter and write-port registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         rd     <= '0;
         rd_din <= '0;
      end else if (run) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q <= op;
                  rd   <= rd_in;
`ifdef MULDIV8_DIV_EN
                  // Divide by zero needs no iteration: answer straight away.
                  if (op[1] && (b == '0)) begin
                     state  <= S_DONE;
                     cnt    <= '0;
                     rd_din <= op[0] ? a : {BITS{1'b1}};
                  end else begin
                     state <= S_CALC;
                     cnt   <= CNT_INIT;
                  end
`else
                  if (op[1]) begin
                     state  <= S_DONE;
                     cnt    <= '0;
                     rd_din <= '0;
                  end else begin
                     state <= S_CALC;
                     cnt   <= CNT_INIT;
                  end
`endif
               end
            end
            S_CALC: begin
               cnt <= cnt - CNT_LAST;
               if (cnt == CNT_LAST) begin
                  state  <= S_DONE;
                  rd_din <= res_calc;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv8.sv
`timescale 1ns/1ps
module tb_muldiv8;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic       start;
   logic [1:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] rd_in;
   logic       busy;
   logic       done;
   logic       we;
   logic [2:0] rd;
   logic [7:0] rd_din;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] rd;
      logic [7:0] data;
      int         lat;
   } exp_t;

   exp_t sb[$];

   muldiv8 #(.BITS(8), .RBITS(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (run),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .we     (we),
      .rd     (rd),
      .rd_din (rd_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain unsigned arithmetic, latency counted from the accept edge.
   function automatic exp_t model(input logic [1:0] o, input logic [7:0] x,
                                  input logic [7:0] y, input logic [2:0] r);
      exp_t e;
      logic [15:0] p;
      p = 16'(x) * 16'(y);
      e.rd  = r;
      e.lat = 9;
      e.data = 8'h00;
      case (o)
         2'b00: e.data = p[7:0];
         2'b01: e.data = p[15:8];
         default: begin
`ifdef MULDIV8_DIV_EN
            if (y == 8'h00) begin
               e.lat  = 1;
               e.data = o[0] ? x : 8'hFF;
            end else begin
               e.data = o[0] ? (x % y) : (x / y);
            end
`else
            e.lat  = 1;
            e.data = 8'h00;
`endif
         end
      endcase
      return e;
   endfunction

   // One transaction: accept, optional run=0 window (cycles s_from..s_to after
   // the accept edge), optional start held high while busy.
   task automatic do_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] r, input int s_from, input int s_to, input bit keep);
      exp_t e;
      int   cyc;
      bit   got;
      e = model(o, x, y, r);
      if (s_to >= s_from) e.lat = e.lat + (s_to - s_from + 1);
      sb.push_back(e);
      op = o; a = x; b = y; rd_in = r; start = 1'b1; run = 1'b1;
      tick();
      start = keep;
      a = 8'($urandom); b = 8'($urandom); rd_in = 3'($urandom);
      if (keep) op = 2'($urandom);
      cyc = 1;
      got = 1'b0;
      while (!got && cyc <= 40) begin
         run = !(cyc >= s_from && cyc <= s_to);
         if (we === 1'b1) begin
            got = 1'b1;
         end else begin
            chk("busy_calc", 32'(busy), 32'd1);
            tick();
            cyc++;
         end
      end
      start = 1'b0;
      run   = 1'b1;
      e = sb.pop_front();
      if (!got) begin
         chk("timeout", 32'(cyc), 32'(e.lat));
      end else begin
         chk("latency", 32'(cyc), 32'(e.lat));
         chk("rd", 32'(rd), 32'(e.rd));
         chk("rd_din", 32'(rd_din), 32'(e.data));
         chk("done", 32'(done), 32'd1);
      end
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_we", 32'(we), 32'd0);
      chk("idle_hold", 32'(rd_din), 32'(e.data));
      if (keep) begin
         tick();
         chk("start_not_queued", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      exp_t e;
      int   writes;
      int   pulses;

      rst_n = 1'b0; run = 1'b1; start = 1'b0; op = 2'b00;
      a = 8'h00; b = 8'h00; rd_in = 3'd0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_rd", 32'(rd), 32'd0);
      chk("rst_rd_din", 32'(rd_din), 32'd0);
      rst_n = 1'b1;
      tick();

      // Directed arithmetic
      do_op(2'b00, 8'd13, 8'd11, 3'd2, 0, -1, 1'b0);
      do_op(2'b01, 8'd200, 8'd200, 3'd3, 0, -1, 1'b0);
      do_op(2'b00, 8'd200, 8'd200, 3'd4, 0, -1, 1'b0);
      do_op(2'b10, 8'd200, 8'd7, 3'd5, 0, -1, 1'b0);
      do_op(2'b11, 8'd200, 8'd7, 3'd6, 0, -1, 1'b0);
      do_op(2'b10, 8'h55, 8'h00, 3'd1, 0, -1, 1'b0);
      do_op(2'b11, 8'h55, 8'h00, 3'd7, 0, -1, 1'b0);
      do_op(2'b01, 8'hFF, 8'hFF, 3'd0, 0, -1, 1'b0);
      do_op(2'b00, 8'hA7, 8'h00, 3'd1, 0, -1, 1'b0);
      do_op(2'b10, 8'h05, 8'hFF, 3'd2, 0, -1, 1'b0);

      // run=0 in CALC cycles 4..6 stretches latency to 12
      do_op(2'b00, 8'd13, 8'd11, 3'd2, 4, 6, 1'b0);

      // start held high while busy is ignored and not queued
      do_op(2'b00, 8'd200, 8'd3, 3'd4, 0, -1, 1'b1);

      // run=0 in DONE: we held, exactly one run-qualified write
      e = model(2'b00, 8'd13, 8'd11, 3'd5);
      sb.push_back(e);
      op = 2'b00; a = 8'd13; b = 8'd11; rd_in = 3'd5; start = 1'b1; run = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      writes = 0;
      for (int c = 9; c <= 12; c++) begin
         run = (c == 12);
         chk("dstall_we", 32'(we), 32'd1);
         if (we && run) writes++;
         tick();
      end
      e = sb.pop_front();
      chk("dstall_data", 32'(rd_din), 32'(e.data));
      chk("dstall_rd", 32'(rd), 32'(e.rd));
      chk("dstall_after_we", 32'(we), 32'd0);
      chk("dstall_writes", 32'(writes), 32'd1);

      // Reset in CALC cycle 5: everything clears, no write pulse follows
      op = 2'b00; a = 8'd13; b = 8'd11; rd_in = 3'd6; start = 1'b1; run = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_we", 32'(we), 32'd0);
      chk("mid_rst_rd", 32'(rd), 32'd0);
      chk("mid_rst_rd_din", 32'(rd_din), 32'd0);
      rst_n = 1'b1;
      pulses = 0;
      repeat (12) begin
         tick();
         if (we === 1'b1) pulses++;
      end
      chk("mid_rst_no_we", 32'(pulses), 32'd0);

      // Random operations against the model
      for (int i = 0; i < 8; i++) begin
         do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)),
               3'($urandom), 0, -1, 1'b0);
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
